pc_next_stage: RTL and testbench

//  Program-counter stage of the single-issue MIPS datapath. Holds PC and selects next PC:

---
 rtl/pc_next_stage_if.sv | 38 +++
 rtl/pc_next_stage.sv | 147 ++++++++++++++
 tb/tb_pc_next_stage.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_next_stage_if.sv
// pc_next_stage_if
//   Bundles the PC stage's control inputs, fetch handshake and PC outputs.
//   master : the PC stage (consumes controls/Imem_Ready, drives PC and status)
//   slave  : the surrounding datapath / instruction memory side
//   Signals:
//     PC_Stall, Halt, Branch_Taken, Branch_Offset[31:0], Jump, Jump_Address[31:0],
//     Jump_Reg, Reg_Address[31:0], Imem_Ready                  -> into the stage
//     PC[31:0], PC_Plus4[31:0], PC_Upper[3:0], Fetch_Valid,
//     Halted, Addr_Error                                       <- from the stage
interface pc_next_stage_if;
  logic        PC_Stall;
  logic        Halt;
  logic        Branch_Taken;
  logic [31:0] Branch_Offset;
  logic        Jump;
  logic [31:0] Jump_Address;
  logic        Jump_Reg;
  logic [31:0] Reg_Address;
  logic        Imem_Ready;
  logic [31:0] PC;
  logic [31:0] PC_Plus4;
  logic [3:0]  PC_Upper;
  logic        Fetch_Valid;
  logic        Halted;
  logic        Addr_Error;

  modport master (
    input  PC_Stall, Halt, Branch_Taken, Branch_Offset, Jump, Jump_Address,
           Jump_Reg, Reg_Address, Imem_Ready,
    output PC, PC_Plus4, PC_Upper, Fetch_Valid, Halted, Addr_Error
  );

  modport slave (
    output PC_Stall, Halt, Branch_Taken, Branch_Offset, Jump, Jump_Address,
           Jump_Reg, Reg_Address, Imem_Ready,
    input  PC, PC_Plus4, PC_Upper, Fetch_Valid, Halted, Addr_Error
  );
endinterface

// File: rtl/pc_next_stage.sv
// pc_next_stage
//   Program-counter stage of the single-issue MIPS datapath. Holds the PC,
//   selects the next PC (jr/jalr > j/jal > taken branch > pending redirect >
//   PC+4) and presents it to instruction memory with a valid/ready handshake.
//   Redirects that arrive while the PC cannot advance are parked in a
//   one-entry pending register and consumed by the next accepted fetch.
//   Ports:
//     clk    - rising-edge clock
//     reset  - asynchronous, active-high reset
//     bus    - pc_next_stage_if.master (controls in, PC / handshake out)
//   Parameters:
//     RESET_PC   - PC loaded on reset (bits [1:0] must be 00)
//     BOOT_DELAY - cycles in BOOT before the first fetch (1..15)
//   Optional feature macro PC_ALIGN_CHECK_EN:
//     defined   - a misaligned target at advance leaves PC unchanged, sets the
//                 sticky Addr_Error and halts the stage
//     undefined - target bits [1:0] are forced to 00, Addr_Error is 0
module pc_next_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned BOOT_DELAY = 1
) (
  input  logic             clk,
  input  logic             reset,
  pc_next_stage_if.master  bus
);

  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;
  localparam logic [3:0] BOOT_LAST = 4'(BOOT_DELAY - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  boot_cnt_q, boot_cnt_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;

  logic [31:0] pc_plus4;
  logic [31:0] branch_tgt;
  logic [31:0] live_tgt;
  logic [31:0] raw_tgt;
  logic [31:0] sel_tgt;
  logic        live_redirect;
  logic        adv;

  assign pc_plus4      = pc_q + 32'd4;
  // Shifting the full word drops offset bits [31:30], as intended.
  assign branch_tgt    = pc_plus4 + (bus.Branch_Offset << 2);
  assign live_redirect = bus.Jump_Reg | bus.Jump | bus.Branch_Taken;
  assign live_tgt      = bus.Jump_Reg ? bus.Reg_Address :
                         bus.Jump     ? bus.Jump_Address : branch_tgt;
  assign raw_tgt       = live_redirect ? live_tgt :
                         pend_valid_q  ? pend_tgt_q : pc_plus4;
  assign adv           = (state_q == ST_FETCH) & bus.Imem_Ready & ~bus.PC_Stall & ~bus.Halt;

`ifdef PC_ALIGN_CHECK_EN
  logic addr_err_q, addr_err_d;
  logic misaligned;
  assign sel_tgt    = raw_tgt;
  assign misaligned = |sel_tgt[1:0];
`else
  assign sel_tgt    = raw_tgt & 32'hFFFF_FFFC;
`endif

  always_comb begin
    state_d      = state_q;
    boot_cnt_d   = boot_cnt_q;
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_tgt_d   = pend_tgt_q;
`ifdef PC_ALIGN_CHECK_EN
    addr_err_d   = addr_err_q;
`endif
    case (state_q)
      ST_BOOT: begin
        if (bus.Halt) begin
          state_d      = ST_HALTED;
          pend_valid_d = 1'b0;
        end else begin
          if (boot_cnt_q == BOOT_LAST) state_d = ST_FETCH;
          else                         boot_cnt_d = boot_cnt_q + 4'd1;
          // Redirects seen during boot are parked for the first fetch.
          if (live_redirect) begin
            pend_valid_d = 1'b1;
            pend_tgt_d   = live_tgt;
          end
        end
      end
      ST_FETCH: begin
        if (bus.Halt) begin
          state_d      = ST_HALTED;
          pend_valid_d = 1'b0;
        end else if (adv) begin
          // Any advance consumes the pending entry, whether or not it was used.
          pend_valid_d = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
          if (misaligned) begin
            addr_err_d = 1'b1;
            state_d    = ST_HALTED;
          end else begin
            pc_d = sel_tgt;
          end
`else
          pc_d = sel_tgt;
`endif
        end else if (live_redirect) begin
          pend_valid_d = 1'b1;
          pend_tgt_d   = live_tgt;
        end
      end
      default: ; // HALTED (and unused encodings) hold until reset
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_BOOT;
      boot_cnt_q   <= 4'd0;
      pc_q         <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_tgt_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      boot_cnt_q   <= boot_cnt_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_tgt_q   <= pend_tgt_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) addr_err_q <= 1'b0;
    else       addr_err_q <= addr_err_d;
  end
  assign bus.Addr_Error = addr_err_q;
`else
  assign bus.Addr_Error = 1'b0;
`endif

  assign bus.PC          = pc_q;
  assign bus.PC_Plus4    = pc_plus4;
  assign bus.PC_Upper    = pc_plus4[31:28];
  assign bus.Fetch_Valid = (state_q == ST_FETCH);
  assign bus.Halted      = (state_q == ST_HALTED);

endmodule

// File: tb/tb_pc_next_stage.sv
// tb_pc_next_stage
//   Directed scenarios with literal expectations, then randomized stimulus.
//   A behavioural model of the PC stage is compared against the DUT on every
//   falling clock edge.
module tb_pc_next_stage;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          BOOT_DELAY = 1;
  localparam int          M_BOOT = 0, M_FETCH = 1, M_HALT = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  bit   cmp_en = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  pc_next_stage_if bus ();

  pc_next_stage #(.RESET_PC(RESET_PC), .BOOT_DELAY(BOOT_DELAY)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_mode;
  int          m_boot;
  logic [31:0] m_pc;
  logic        m_pv;
  logic [31:0] m_pt;
  logic        m_err;

  function automatic logic redirect_now();
    return bus.Jump_Reg || bus.Jump || bus.Branch_Taken;
  endfunction

  function automatic logic [31:0] live_target();
    if (bus.Jump_Reg) return bus.Reg_Address;
    if (bus.Jump)     return bus.Jump_Address;
    return m_pc + 32'd4 + bus.Branch_Offset * 32'd4;
  endfunction

  function automatic logic [31:0] chosen_target();
    if (redirect_now()) return live_target();
    if (m_pv)           return m_pt;
    return m_pc + 32'd4;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode <= M_BOOT; m_boot <= 0; m_pc <= RESET_PC;
      m_pv <= 1'b0; m_pt <= 32'd0; m_err <= 1'b0;
    end else if (m_mode == M_HALT) begin
      // only reset leaves HALTED
    end else if (bus.Halt) begin
      m_mode <= M_HALT; m_pv <= 1'b0;
    end else if (m_mode == M_BOOT) begin
      if (m_boot + 1 >= BOOT_DELAY) m_mode <= M_FETCH;
      else                          m_boot <= m_boot + 1;
      if (redirect_now()) begin m_pv <= 1'b1; m_pt <= live_target(); end
    end else if (bus.Imem_Ready && !bus.PC_Stall) begin
      m_pv <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      if (chosen_target() % 4 != 0) begin
        m_err <= 1'b1; m_mode <= M_HALT;
      end else begin
        m_pc <= chosen_target();
      end
`else
      m_pc <= chosen_target() & 32'hFFFF_FFFC;
`endif
    end else if (redirect_now()) begin
      m_pv <= 1'b1; m_pt <= live_target();
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_pc",       bus.PC,                 m_pc);
      chk("model_pc_plus4", bus.PC_Plus4,           m_pc + 32'd4);
      chk("model_pc_upper", 32'(bus.PC_Upper),      (m_pc + 32'd4) >> 28);
      chk("model_fvalid",   32'(bus.Fetch_Valid),   32'(m_mode == M_FETCH));
      chk("model_halted",   32'(bus.Halted),        32'(m_mode == M_HALT));
      chk("model_addr_err", 32'(bus.Addr_Error),    32'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.PC_Stall = 1'b0; bus.Halt = 1'b0; bus.Branch_Taken = 1'b0;
    bus.Branch_Offset = 32'd0; bus.Jump = 1'b0; bus.Jump_Address = 32'd0;
    bus.Jump_Reg = 1'b0; bus.Reg_Address = 32'd0; bus.Imem_Ready = 1'b1;
  endtask

  task automatic jr_to(input logic [31:0] addr);
    bus.Jump_Reg = 1'b1; bus.Reg_Address = addr;
    tick();
    bus.Jump_Reg = 1'b0;
  endtask

  int halt_cycles;

  initial begin
    idle();
    #2 reset = 1'b1;
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // 1: reset state, boot, sequential fetch
    chk("rst_pc",     bus.PC, RESET_PC);
    chk("rst_fvalid", 32'(bus.Fetch_Valid), 32'd0);
    chk("rst_halted", 32'(bus.Halted), 32'd0);
    chk("rst_aerr",   32'(bus.Addr_Error), 32'd0);
    reset = 1'b0;
    tick();
    chk("boot_fvalid", 32'(bus.Fetch_Valid), 32'd1);
    chk("seq_pc0", bus.PC, 32'h0);
    tick(); chk("seq_pc4", bus.PC, 32'h4);
    tick(); chk("seq_pc8", bus.PC, 32'h8);
    tick(); chk("seq_pcC", bus.PC, 32'hC);
    chk("seq_upper", 32'(bus.PC_Upper), 32'd0);
    $display("test 1 sequential fetch done");

    // 2: branch target, jump beats branch
    jr_to(32'h0040_0010);
    chk("jr_pc", bus.PC, 32'h0040_0010);
    bus.Branch_Taken = 1'b1; bus.Branch_Offset = 32'hFFFF_FFFE;
    tick();
    bus.Branch_Taken = 1'b0;
    chk("branch_back", bus.PC, 32'h0040_000C);
    jr_to(32'h0040_0010);
    bus.Branch_Taken = 1'b1; bus.Branch_Offset = 32'hFFFF_FFFE;
    bus.Jump = 1'b1; bus.Jump_Address = 32'h0010_0000;
    tick();
    idle();
    chk("jump_over_branch", bus.PC, 32'h0010_0000);
    $display("test 2 branch/jump priority done");

    // 3: redirect parked while Imem_Ready=0
    bus.Imem_Ready = 1'b0; bus.Jump_Reg = 1'b1; bus.Reg_Address = 32'h0000_1000;
    tick();
    bus.Jump_Reg = 1'b0;
    chk("notready_pc", bus.PC, 32'h0010_0000);
    chk("notready_fv", 32'(bus.Fetch_Valid), 32'd1);
    tick(); tick();
    chk("notready_pc3", bus.PC, 32'h0010_0000);
    bus.Imem_Ready = 1'b1;
    tick(); chk("pending_used", bus.PC, 32'h0000_1000);
    tick(); chk("pending_clear", bus.PC, 32'h0000_1004);
    $display("test 3 pending redirect done");

    // 4: PC_Upper and wrap-around
    jr_to(32'h6FFF_FFFC);
    chk("upper7", 32'(bus.PC_Upper), 32'd7);
    jr_to(32'hFFFF_FFFC);
    chk("pc_top", bus.PC, 32'hFFFF_FFFC);
    chk("plus4_wrap", bus.PC_Plus4, 32'h0);
    tick(); chk("pc_wrap", bus.PC, 32'h0);
    chk("upper_wrap", 32'(bus.PC_Upper), 32'd0);
    tick(); chk("pc_after_wrap", bus.PC, 32'h4);
    $display("test 4 wrap-around done");

    // 5: halt during stall, then reset while halted
    bus.PC_Stall = 1'b1; bus.Halt = 1'b1;
    tick();
    idle();
    chk("halt_halted", 32'(bus.Halted), 32'd1);
    chk("halt_fv", 32'(bus.Fetch_Valid), 32'd0);
    chk("halt_pc", bus.PC, 32'h4);
    tick(); tick();
    chk("halt_pc_frozen", bus.PC, 32'h4);
    reset = 1'b1;
    #1;
    chk("rst_halted_pc", bus.PC, RESET_PC);
    chk("rst_halted_h", 32'(bus.Halted), 32'd0);
    chk("rst_halted_fv", 32'(bus.Fetch_Valid), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    $display("test 5 halt/reset done");

    // 6: misaligned jump-register target
    jr_to(32'h0000_1002);
`ifdef PC_ALIGN_CHECK_EN
    chk("mis_pc", bus.PC, 32'h0);
    chk("mis_aerr", 32'(bus.Addr_Error), 32'd1);
    chk("mis_halted", 32'(bus.Halted), 32'd1);
`else
    chk("mis_pc", bus.PC, 32'h0000_1000);
    chk("mis_aerr", 32'(bus.Addr_Error), 32'd0);
`endif
    $display("test 6 misaligned target done");

    // randomized phase
    reset = 1'b1;
    tick();
    reset = 1'b0;
    halt_cycles = 0;
    for (int i = 0; i < 4000; i++) begin
      logic [15:0] imm;
      logic [31:0] r;
      imm = 16'($urandom);
      r   = $urandom;
      bus.Imem_Ready    = ($urandom_range(0, 9) < 7);
      bus.PC_Stall      = ($urandom_range(0, 9) < 2);
      bus.Halt          = ($urandom_range(0, 149) == 0);
      bus.Branch_Taken  = ($urandom_range(0, 5) == 0);
      bus.Branch_Offset = {{16{imm[15]}}, imm};
      bus.Jump          = ($urandom_range(0, 9) == 0);
      bus.Jump_Address  = {(m_pc[31:28] + ((m_pc[27:0] == 28'hFFFFFFC) ? 4'd1 : 4'd0)), r[25:0], 2'b00};
      bus.Jump_Reg      = ($urandom_range(0, 9) == 0);
      bus.Reg_Address   = ($urandom_range(0, 7) == 0) ? $urandom : {r[31:2], 2'b00};
      if (m_mode == M_HALT) halt_cycles++;
      else                  halt_cycles = 0;
      reset = (halt_cycles > 15) || ($urandom_range(0, 599) == 0);
      if (reset) halt_cycles = 0;
      tick();
    end
    reset = 1'b0;
    idle();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
